edm_pulse_gen: RTL and testbench
================================

EDM_PULSE_GEN -- requirements
Module: edm_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the timing fields and the pulse counter.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port machine_start, input, 1, single-cycle request from the SPI command decoder to begin pulsing.
REQ-005 SHALL have port machine_stop, input, 1, single-cycle request from the SPI command decoder to halt pulsing.
REQ-006 SHALL have port Ton_data, input, CNT_W, pulse-on duration in clk cycles.
REQ-007 SHALL have port Toff_data, input, CNT_W, pulse-off duration in clk cycles.
REQ-008 SHALL have port sc_detect, input, 1, synchronous active-high gap short-circuit flag.
REQ-009 SHALL have port pulse_out, output, 1, registered discharge gate drive.
REQ-010 SHALL have port running, output, 1, high while not IDLE.
REQ-011 SHALL have port param_error, output, 1, sticky flag for a start refused because of zero timing.
REQ-012 SHALL have port feedback_data, output, CNT_W, count of pulses since the last accepted start; feeds the SPI feedback path.

Function
REQ-013 SHALL implement states IDLE, TON and TOFF.
REQ-014 SHALL go IDLE->TON on machine_start when Ton_data!=0 and Toff_data!=0, latching both values into shadow registers, clearing feedback_data and clearing param_error.
REQ-015 SHALL stay in IDLE and set param_error on machine_start when Ton_data==0 or Toff_data==0.
REQ-016 SHALL drive pulse_out high starting the cycle after an accepted start, for exactly shadow Ton cycles, then low for exactly shadow Toff cycles, repeating.
REQ-017 SHALL make pulse_out a registered decode of state (TON=1, all other states 0), with no combinational path from inputs.
REQ-018 SHALL re-latch the shadow registers from Ton_data/Toff_data only on the TOFF->TON transition, so a mid-period parameter change takes effect at the next period.
REQ-019 SHALL, when the re-latch in REQ-018 would load a zero value, keep the old shadow values and set param_error.
REQ-020 SHALL increment feedback_data on every entry into TON, wrapping from all-ones to 0.
REQ-021 SHALL, when sc_detect is high in TON, go to TOFF on the next edge (pulse truncated) and start a full Toff period; sc_detect SHALL be ignored in TOFF and IDLE.
REQ-022 SHALL, on machine_stop in TON or TOFF, go to IDLE on the next edge, with pulse_out low from that edge.
REQ-023 SHALL give machine_stop priority when machine_stop and machine_start are asserted in the same cycle.
REQ-024 SHALL ignore machine_start while running.
REQ-025 SHALL give machine_stop priority over sc_detect and over a period-end transition in the same cycle.
REQ-026 SHALL load a single down-counter with shadow value minus 1 at each state entry; the state SHALL advance when the counter reads 0.

Reset
REQ-027 SHALL, while rst is low, hold state IDLE, pulse_out=0, running=0, param_error=0, feedback_data=0, shadow registers=0 and counter=0.
REQ-028 SHALL, on reset mid-pulse, drop pulse_out asynchronously, and SHALL NOT resume pulsing after reset without a new machine_start.

Structure
REQ-029 SHALL take its state encodings (2-bit) and the default CNT_W from the shared SPI/EDM package also used by the command decoder.
REQ-030 SHALL be a single module with no sub-module; the counter, shadow registers and FSM are inline.

Verification
REQ-031 SHALL cover basic pulsing: Ton=3, Toff=5, start -> pulse_out high 3 cycles, low 5 cycles, repeating; feedback_data=1,2,3...
REQ-032 SHALL cover a parameter change: set Ton=10 during TON of Ton=3 -> the current pulse is 3 cycles and the next pulse is 10 cycles.
REQ-033 SHALL cover zero timing: Toff=0 then start -> running=0, param_error=1, pulse_out stays 0.
REQ-034 SHALL cover short-circuit: sc_detect pulsed on the 2nd cycle of Ton=8 -> pulse_out low after 2 high cycles, then 5 low cycles (Toff=5).
REQ-035 SHALL cover simultaneous start and stop: both asserted in IDLE -> remains IDLE; both asserted in TON -> IDLE next edge.
REQ-036 SHALL cover counter wrap: feedback_data forced to FFFF, then the next pulse -> 0000.

Source files
------------

// File: rtl/edm_pulse_gen_pkg.sv
// edm_pulse_gen_pkg: shared SPI/EDM definitions (pulse FSM encodings, default timing width)
package edm_pulse_gen_pkg;
    localparam int DEF_CNT_W = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TON  = 2'd1,
        TOFF = 2'd2
    } state_t;
endpackage

// File: rtl/edm_pulse_gen.sv
// edm_pulse_gen: EDM discharge pulse generator with shadowed Ton/Toff timing,
// short-circuit truncation and a pulse counter for SPI feedback.
module edm_pulse_gen
    import edm_pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             machine_start,
    input  logic             machine_stop,
    input  logic [CNT_W-1:0] Ton_data,
    input  logic [CNT_W-1:0] Toff_data,
    input  logic             sc_detect,
    output logic             pulse_out,
    output logic             running,
    output logic             param_error,
    output logic [CNT_W-1:0] feedback_data
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, ton_sh, toff_sh;
    logic params_ok, start_req, cnt_done;

    // Stop outranks start, short-circuit and period end alike
    always_comb begin
        params_ok = (Ton_data != '0) && (Toff_data != '0);
        start_req = machine_start && !machine_stop;
        cnt_done  = (cnt == '0);
        state_nx  = state;
        if (state == IDLE)
            state_nx = (start_req && params_ok) ? TON : IDLE;
        else if (machine_stop)
            state_nx = IDLE;
        else if (state == TON)
            state_nx = (sc_detect || cnt_done) ? TOFF : TON;
        else if (state == TOFF)
            state_nx = cnt_done ? TON : TOFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pulse_out     <= 1'b0;
            param_error   <= 1'b0;
            feedback_data <= '0;
            ton_sh        <= '0;
            toff_sh       <= '0;
            cnt           <= '0;
        end else begin
            state     <= state_nx;
            pulse_out <= (state_nx == TON);
            if (state == IDLE && start_req) begin
                param_error <= !params_ok;
                if (params_ok) begin
                    ton_sh        <= Ton_data;
                    toff_sh       <= Toff_data;
                    cnt           <= Ton_data - 1'b1;
                    feedback_data <= CNT_W'(1);
                end
            end else if (state == TOFF && state_nx == TON) begin
                feedback_data <= feedback_data + 1'b1;
                // A zero re-latch keeps the running period alive on the old values
                if (params_ok) begin
                    ton_sh  <= Ton_data;
                    toff_sh <= Toff_data;
                    cnt     <= Ton_data - 1'b1;
                end else begin
                    param_error <= 1'b1;
                    cnt         <= ton_sh - 1'b1;
                end
            end else if (state == TON && state_nx == TOFF) begin
                cnt <= toff_sh - 1'b1;
            end else if (state_nx == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign running = (state != IDLE);
endmodule

// File: tb/tb_edm_pulse_gen.sv
// tb_edm_pulse_gen: directed checks of pulse timing, re-latch, faults and reset.
module tb_edm_pulse_gen;
    logic        clk = 1'b0, rst = 1'b0, machine_start = 1'b0, machine_stop = 1'b0, sc_detect = 1'b0;
    logic [15:0] Ton_data = '0, Toff_data = '0, feedback_data;
    logic        pulse_out, running, param_error;
    int vectors = 0, miscompares = 0;

    edm_pulse_gen #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .machine_start(machine_start), .machine_stop(machine_stop),
        .Ton_data(Ton_data), .Toff_data(Toff_data), .sc_detect(sc_detect),
        .pulse_out(pulse_out), .running(running), .param_error(param_error),
        .feedback_data(feedback_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] ton, input logic [15:0] toff);
        Ton_data = ton;
        Toff_data = toff;
        machine_start = 1'b1;
        tick();
        machine_start = 1'b0;
    endtask

    task automatic stop_run();
        machine_stop = 1'b1;
        tick();
        machine_stop = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL reset_pulse: got %b exp 0", pulse_out); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b exp 0", running); end
        vectors++; if (param_error !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b exp 0", param_error); end
        vectors++; if (feedback_data !== 16'h0) begin miscompares++; $display("FAIL reset_fb: got %h exp 0000", feedback_data); end
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_run(16'd3, 16'd5);
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (pulse_out !== ((i % 8) < 3)) begin miscompares++; $display("FAIL basic_pulse[%0d]: got %b exp %b", i, pulse_out, (i % 8) < 3); end
            vectors++;
            if (running !== 1'b1) begin miscompares++; $display("FAIL basic_running[%0d]: got %b exp 1", i, running); end
            if (i % 8 == 0) begin
                vectors++;
                if (feedback_data !== 16'(i / 8 + 1)) begin miscompares++; $display("FAIL basic_fb[%0d]: got %0d exp %0d", i, feedback_data, i / 8 + 1); end
            end
            machine_start = (i == 10);
            tick();
        end
        machine_start = 1'b0;
        stop_run();
        vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL stop_pulse: got %b exp 0", pulse_out); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL stop_running: got %b exp 0", running); end
    endtask

    task automatic test_param_change();
        logic exp;
        start_run(16'd3, 16'd5);
        for (int i = 0; i < 34; i++) begin
            exp = (i < 3) || (i >= 8 && i < 18) || (i >= 23 && i < 33);
            vectors++;
            if (pulse_out !== exp) begin miscompares++; $display("FAIL param_pulse[%0d]: got %b exp %b", i, pulse_out, exp); end
            vectors++;
            if (param_error !== (i >= 23)) begin miscompares++; $display("FAIL param_perr[%0d]: got %b exp %b", i, param_error, i >= 23); end
            if (i == 8 || i == 23) begin
                vectors++;
                if (feedback_data !== 16'(i == 8 ? 2 : 3)) begin miscompares++; $display("FAIL param_fb[%0d]: got %0d exp %0d", i, feedback_data, i == 8 ? 2 : 3); end
            end
            if (i == 0) Ton_data = 16'd10;
            if (i == 18) Ton_data = 16'd0;
            tick();
        end
        stop_run();
        Ton_data = 16'd3;
    endtask

    task automatic test_zero_timing();
        start_run(16'd3, 16'd0);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL zero_running[%0d]: got %b exp 0", i, running); end
            vectors++; if (param_error !== 1'b1) begin miscompares++; $display("FAIL zero_perr[%0d]: got %b exp 1", i, param_error); end
            vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL zero_pulse[%0d]: got %b exp 0", i, pulse_out); end
            tick();
        end
        start_run(16'd3, 16'd5);
        vectors++; if (param_error !== 1'b0) begin miscompares++; $display("FAIL zero_clear_perr: got %b exp 0", param_error); end
        vectors++; if (pulse_out !== 1'b1) begin miscompares++; $display("FAIL zero_restart_pulse: got %b exp 1", pulse_out); end
        stop_run();
    endtask

    task automatic test_short_circuit();
        logic exp;
        start_run(16'd8, 16'd5);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 2) || (i >= 7 && i < 15);
            vectors++;
            if (pulse_out !== exp) begin miscompares++; $display("FAIL sc_pulse[%0d]: got %b exp %b", i, pulse_out, exp); end
            sc_detect = (i == 1 || i == 3);
            tick();
        end
        sc_detect = 1'b0;
        stop_run();
    endtask

    task automatic test_start_stop();
        Ton_data = 16'd3;
        Toff_data = 16'd5;
        machine_start = 1'b1;
        machine_stop = 1'b1;
        tick();
        machine_start = 1'b0;
        machine_stop = 1'b0;
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL ss_idle_running: got %b exp 0", running); end
        vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL ss_idle_pulse: got %b exp 0", pulse_out); end
        start_run(16'd3, 16'd5);
        vectors++; if (pulse_out !== 1'b1) begin miscompares++; $display("FAIL ss_ton_pulse: got %b exp 1", pulse_out); end
        machine_start = 1'b1;
        machine_stop = 1'b1;
        tick();
        machine_start = 1'b0;
        machine_stop = 1'b0;
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL ss_ton_running: got %b exp 0", running); end
        vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL ss_ton_stop_pulse: got %b exp 0", pulse_out); end
    endtask

    task automatic test_wrap();
        start_run(16'd2, 16'd2);
        tick();
        tick();
        force dut.feedback_data = 16'hFFFF;
        #1;
        release dut.feedback_data;
        vectors++; if (feedback_data !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preset: got %h exp ffff", feedback_data); end
        tick();
        tick();
        vectors++; if (pulse_out !== 1'b1) begin miscompares++; $display("FAIL wrap_pulse: got %b exp 1", pulse_out); end
        vectors++; if (feedback_data !== 16'h0000) begin miscompares++; $display("FAIL wrap_fb: got %h exp 0000", feedback_data); end
        stop_run();
    endtask

    task automatic test_async_reset();
        start_run(16'd3, 16'd5);
        tick();
        #3 rst = 1'b0;
        #1;
        vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL arst_pulse: got %b exp 0", pulse_out); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL arst_running: got %b exp 0", running); end
        vectors++; if (feedback_data !== 16'h0) begin miscompares++; $display("FAIL arst_fb: got %h exp 0000", feedback_data); end
        #2 rst = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++; if (pulse_out !== 1'b0) begin miscompares++; $display("FAIL arst_resume[%0d]: got %b exp 0", i, pulse_out); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_param_change();
        test_zero_timing();
        test_short_circuit();
        test_start_stop();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
